// File: rtl/conv_rd_addr_gen.sv
// conv_rd_addr_gen
//   Read-side address sequencer for the 2D convolution datapath. Once the
//   ifmd buffer (IFMD_W x IFMD_W, row-major) and kernel buffer are loaded, a
//   start walks every output pixel and, within it, every kernel tap, issuing
//   one ifmd/kernel read-address pair per cycle with MAC framing flags.
//
//   Build option: define ZERO_PAD_EN for "same" convolution (D = IFMD_W, taps
//   outside the map flagged with pad_zero). Without it the block performs
//   "valid" convolution and pad_zero is tied low.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   start             begin a pass (accepted only in IDLE)
//   is_5x5            kernel size select, latched on accepted start
//   stall             freeze the sequence; no tap issued while high
//   busy              high from the cycle after start through the done cycle
//   rd_valid          outputs below carry a valid tap this cycle
//   ifmd_rd_addr      ifmd read address (0 for padded taps)
//   kw_rd_addr        kernel read address, kr*K+kc
//   pad_zero          tap lies outside the map; MAC uses 0
//   acc_first         first tap of the output pixel (clear accumulator)
//   acc_last          last tap of the output pixel (write result)
//   out_addr          output pixel index, orow*D+ocol
//   done              one-cycle pulse after the final tap
module conv_rd_addr_gen #(
  parameter int IFMD_W      = 8,
  parameter int IFMD_ADDR_W = 6,
  parameter int KW_ADDR_W   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   is_5x5,
  input  logic                   stall,
  output logic                   busy,
  output logic                   rd_valid,
  output logic [IFMD_ADDR_W-1:0] ifmd_rd_addr,
  output logic [KW_ADDR_W-1:0]   kw_rd_addr,
  output logic                   pad_zero,
  output logic                   acc_first,
  output logic                   acc_last,
  output logic [IFMD_ADDR_W-1:0] out_addr,
  output logic                   done
);

  localparam int OW = $clog2(IFMD_W);

  // Largest output row/col index (D-1) for each kernel size.
`ifdef ZERO_PAD_EN
  localparam int DMAX3 = IFMD_W - 1;
  localparam int DMAX5 = IFMD_W - 1;
`else
  localparam int DMAX3 = IFMD_W - 3;
  localparam int DMAX5 = IFMD_W - 5;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nx;

  // Counters always point at the next tap to be issued.
  logic          is5_q, is5_nx;
  logic [2:0]    kc, kr, kc_nx, kr_nx;
  logic [OW-1:0] ocol, orow, ocol_nx, orow_nx;
  logic          last_q, last_nx;   // the final tap has been issued

  logic                   busy_nx, rd_valid_nx, done_nx;
  logic [IFMD_ADDR_W-1:0] ifmd_nx, out_nx;
  logic [KW_ADDR_W-1:0]   kw_nx;
  logic                   pad_nx, first_nx, lastf_nx;

  // Tap source and its successor
  logic          k5;
  logic [2:0]    kmax;
  logic [OW-1:0] dmax;
  int            k_i;
  logic [2:0]    s_kc, s_kr, i_kc, i_kr;
  logic [OW-1:0] s_ocol, s_orow, i_ocol, i_orow;
  logic          s_final;

  // Tap arithmetic in int so nothing truncates before the final address.
  int            r_i, c_i;
  logic          pad_t;
  logic [IFMD_ADDR_W-1:0] addr_t;
  logic          issue;

  always_comb begin
    // In IDLE the kernel size comes straight from the input so the first
    // tap can be issued on the accepting edge.
    k5    = (state == S_IDLE) ? is_5x5 : is5_q;
    kmax  = k5 ? 3'd4 : 3'd2;
    dmax  = k5 ? OW'(DMAX5) : OW'(DMAX3);
    k_i   = k5 ? 5 : 3;

    s_kc   = (state == S_IDLE) ? 3'd0  : kc;
    s_kr   = (state == S_IDLE) ? 3'd0  : kr;
    s_ocol = (state == S_IDLE) ? '0    : ocol;
    s_orow = (state == S_IDLE) ? '0    : orow;

    // Nested wrap/carry: kc -> kr -> ocol -> orow
    i_kc   = s_kc + 3'd1;
    i_kr   = s_kr;
    i_ocol = s_ocol;
    i_orow = s_orow;
    if (s_kc == kmax) begin
      i_kc = 3'd0;
      i_kr = s_kr + 3'd1;
      if (s_kr == kmax) begin
        i_kr   = 3'd0;
        i_ocol = s_ocol + OW'(1);
        if (s_ocol == dmax) begin
          i_ocol = '0;
          i_orow = (s_orow == dmax) ? '0 : s_orow + OW'(1);
        end
      end
    end
    s_final = (s_kc == kmax) && (s_kr == kmax) &&
              (s_ocol == dmax) && (s_orow == dmax);

    r_i = int'(s_orow) + int'(s_kr);
    c_i = int'(s_ocol) + int'(s_kc);
`ifdef ZERO_PAD_EN
    // Centre the window: shift by P = (K-1)/2 = kmax/2.
    r_i   = r_i - int'(kmax) / 2;
    c_i   = c_i - int'(kmax) / 2;
    pad_t = (r_i < 0) || (r_i >= IFMD_W) || (c_i < 0) || (c_i >= IFMD_W);
`else
    pad_t = 1'b0;
`endif
    addr_t = pad_t ? '0 : IFMD_ADDR_W'(r_i * IFMD_W + c_i);

    // Next-state / next-output defaults: hold everything, no pulse.
    state_nx    = state;
    is5_nx      = is5_q;
    kc_nx       = kc;
    kr_nx       = kr;
    ocol_nx     = ocol;
    orow_nx     = orow;
    last_nx     = last_q;
    busy_nx     = busy;
    rd_valid_nx = 1'b0;
    done_nx     = 1'b0;
    ifmd_nx     = ifmd_rd_addr;
    kw_nx       = kw_rd_addr;
    pad_nx      = pad_zero;
    first_nx    = acc_first;
    lastf_nx    = acc_last;
    out_nx      = out_addr;
    issue       = 1'b0;

    case (state)
      S_IDLE: begin
        busy_nx = 1'b0;
        if (start) begin
          state_nx = S_RUN;
          is5_nx   = is_5x5;
          busy_nx  = 1'b1;
          issue    = 1'b1;
        end
      end
      S_RUN: begin
        if (stall) begin
          // hold counters and outputs; rd_valid already defaults low
        end else if (last_q) begin
          state_nx = S_DONE;
          done_nx  = 1'b1;
        end else begin
          issue = 1'b1;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        busy_nx  = 1'b0;
      end
      default: state_nx = S_IDLE;
    endcase

    if (issue) begin
      rd_valid_nx = 1'b1;
      ifmd_nx     = addr_t;
      kw_nx       = KW_ADDR_W'(int'(s_kr) * k_i + int'(s_kc));
      pad_nx      = pad_t;
      first_nx    = (s_kr == 3'd0) && (s_kc == 3'd0);
      lastf_nx    = (s_kr == kmax) && (s_kc == kmax);
      out_nx      = IFMD_ADDR_W'(int'(s_orow) * (int'(dmax) + 1) + int'(s_ocol));
      kc_nx       = i_kc;
      kr_nx       = i_kr;
      ocol_nx     = i_ocol;
      orow_nx     = i_orow;
      last_nx     = s_final;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      is5_q        <= 1'b0;
      kc           <= 3'd0;
      kr           <= 3'd0;
      ocol         <= '0;
      orow         <= '0;
      last_q       <= 1'b0;
      busy         <= 1'b0;
      rd_valid     <= 1'b0;
      done         <= 1'b0;
      ifmd_rd_addr <= '0;
      kw_rd_addr   <= '0;
      pad_zero     <= 1'b0;
      acc_first    <= 1'b0;
      acc_last     <= 1'b0;
      out_addr     <= '0;
    end else begin
      state        <= state_nx;
      is5_q        <= is5_nx;
      kc           <= kc_nx;
      kr           <= kr_nx;
      ocol         <= ocol_nx;
      orow         <= orow_nx;
      last_q       <= last_nx;
      busy         <= busy_nx;
      rd_valid     <= rd_valid_nx;
      done         <= done_nx;
      ifmd_rd_addr <= ifmd_nx;
      kw_rd_addr   <= kw_nx;
      pad_zero     <= pad_nx;
      acc_first    <= first_nx;
      acc_last     <= lastf_nx;
      out_addr     <= out_nx;
    end
  end

endmodule

// File: tb/tb_conv_rd_addr_gen.sv
// Self-checking bench for conv_rd_addr_gen. A tap-index model (pixel/tap
// decomposition by division) predicts every output each cycle; directed
// passes add literal checks on counts, done timing and specific taps.
module tb_conv_rd_addr_gen;

  localparam int IW = 8;
  localparam int AW = 6;
  localparam int KW = 5;

`ifdef ZERO_PAD_EN
  localparam int N3 = 576;
  localparam int N5 = 1600;
`else
  localparam int N3 = 324;
  localparam int N5 = 400;
`endif

  logic          clk = 1'b0;
  logic          rst, start, is_5x5, stall;
  logic          busy, rd_valid, pad_zero, acc_first, acc_last, done;
  logic [AW-1:0] ifmd_rd_addr, out_addr;
  logic [KW-1:0] kw_rd_addr;

  int checks = 0;
  int failures = 0;

  conv_rd_addr_gen #(.IFMD_W(IW), .IFMD_ADDR_W(AW), .KW_ADDR_W(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .is_5x5(is_5x5), .stall(stall),
    .busy(busy), .rd_valid(rd_valid), .ifmd_rd_addr(ifmd_rd_addr),
    .kw_rd_addr(kw_rd_addr), .pad_zero(pad_zero), .acc_first(acc_first),
    .acc_last(acc_last), .out_addr(out_addr), .done(done)
  );

  always #5 clk = ~clk;

  // Tap t of a pass with kernel size k, straight from the definitions.
  function automatic void tap_of(input int k, input int t, output int ifa,
                                 output int kw, output int oa, output bit pz,
                                 output bit af, output bit al);
    int d, p, pix, w, orow, ocol, kr, kc, r, c;
`ifdef ZERO_PAD_EN
    d = IW; p = (k - 1) / 2;
`else
    d = IW - k + 1; p = 0;
`endif
    pix = t / (k * k); w = t % (k * k);
    orow = pix / d; ocol = pix % d;
    kr = w / k; kc = w % k;
    r = orow + kr - p; c = ocol + kc - p;
    if (r < 0 || r >= IW || c < 0 || c >= IW) begin pz = 1'b1; ifa = 0; end
    else begin pz = 1'b0; ifa = r * IW + c; end
    kw = kr * k + kc;
    oa = pix;
    af = (w == 0);
    al = (w == k * k - 1);
  endfunction

  function automatic int n_taps(input int k);
`ifdef ZERO_PAD_EN
    return IW * IW * k * k;
`else
    return (IW - k + 1) * (IW - k + 1) * k * k;
`endif
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // ---------------- cycle model + compare process ----------------
  int m_phase, m_idx, m_n, m_k;
  bit m_en = 1'b0;
  bit e_busy, e_valid, e_done, e_chk;
  int e_ifa, e_kw, e_oa;
  bit e_pz, e_af, e_al;

  initial forever begin
    @(negedge clk);
    if (m_en) begin
      checks++;
      if ({busy, rd_valid, done} !== {e_busy, e_valid, e_done}) begin
        failures++;
        $display("FAIL ctrl @%0t: busy/valid/done got %b%b%b expected %b%b%b",
                 $time, busy, rd_valid, done, e_busy, e_valid, e_done);
      end
      if (e_valid || e_chk) begin
        checks++;
        if (ifmd_rd_addr !== AW'(e_ifa) || kw_rd_addr !== KW'(e_kw) ||
            out_addr !== AW'(e_oa) || pad_zero !== e_pz ||
            acc_first !== e_af || acc_last !== e_al) begin
          failures++;
          $display("FAIL tap @%0t: ifmd/kw/out/pad/first/last got %0d/%0d/%0d/%b%b%b expected %0d/%0d/%0d/%b%b%b",
                   $time, ifmd_rd_addr, kw_rd_addr, out_addr, pad_zero, acc_first, acc_last,
                   e_ifa, e_kw, e_oa, e_pz, e_af, e_al);
        end
      end
    end
    // Predict the next cycle from the inputs sampled at the coming edge.
    if (rst !== 1'b1) begin
      m_en = 1'b1; m_phase = 0;
      e_busy = 0; e_valid = 0; e_done = 0; e_chk = 1;
      e_ifa = 0; e_kw = 0; e_oa = 0; e_pz = 0; e_af = 0; e_al = 0;
    end else begin
      e_done = 0;
      case (m_phase)
        0: begin
          e_valid = 0; e_chk = 0;
          if (start) begin
            m_k = is_5x5 ? 5 : 3; m_n = n_taps(m_k); m_idx = 0;
            tap_of(m_k, m_idx, e_ifa, e_kw, e_oa, e_pz, e_af, e_al);
            m_idx++; e_valid = 1; e_busy = 1; m_phase = 1;
          end
        end
        1: begin
          if (stall) begin e_valid = 0; e_chk = 1; end
          else if (m_idx == m_n) begin
            e_valid = 0; e_chk = 0; e_done = 1; m_phase = 2;
          end else begin
            tap_of(m_k, m_idx, e_ifa, e_kw, e_oa, e_pz, e_af, e_al);
            m_idx++; e_valid = 1; e_chk = 0;
          end
        end
        default: begin
          e_busy = 0; e_valid = 0; e_chk = 0; m_phase = 0;
        end
      endcase
    end
  end

  // ---------------- directed stimulus ----------------
  int cap_ifa[1:1700], cap_kw[1:1700], cap_oa[1:1700];
  bit cap_pz[1:1700], cap_af[1:1700], cap_al[1:1700];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Called in cycle 1 of a pass (start already sampled). Drives per-cycle
  // stall/start/is_5x5/rst patterns and records every valid tap.
  task automatic watch_pass(input int stall_at, input int stall_len,
                            input int sp_a, input int sp_b, input int sp_c,
                            input bit tog, input int rst_at,
                            output int nvalid, output int dcyc);
    bit fin;
    nvalid = 0; dcyc = -1; fin = 0;
    for (int cyc = 1; cyc <= 4000 && !fin; cyc++) begin
      stall = (stall_len > 0 && cyc >= stall_at - 1 && cyc <= stall_at + stall_len - 2);
      start = (cyc >= sp_a && cyc <= sp_b) || cyc == sp_c;
      if (tog) is_5x5 = ~is_5x5;
      rst = (cyc == rst_at) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (rd_valid === 1'b1 && nvalid < 1700) begin
        nvalid++;
        cap_ifa[nvalid] = int'(ifmd_rd_addr); cap_kw[nvalid] = int'(kw_rd_addr);
        cap_oa[nvalid] = int'(out_addr); cap_pz[nvalid] = pad_zero;
        cap_af[nvalid] = acc_first; cap_al[nvalid] = acc_last;
      end
      if (done === 1'b1) dcyc = cyc;
      tick();
      if (dcyc >= 0 || cyc == rst_at) fin = 1;
    end
    stall = 0; start = 0; rst = 1;
    if (!fin) begin
      checks++; failures++;
      $display("FAIL pass_timeout: got no done within 4000 cycles expected done");
    end
  endtask

  int nv, dc;
  int t_ifa, t_kw, t_oa;
  bit t_pz, t_af, t_al;

  initial begin
    rst = 0; start = 0; stall = 0; is_5x5 = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset rd_valid", int'(rd_valid), 0);
    chk("reset ifmd", int'(ifmd_rd_addr), 0);
    chk("reset done", int'(done), 0);
    tick(); rst = 1;
    tick();

    // Pin the model against hand-computed taps
`ifndef ZERO_PAD_EN
    tap_of(3, 8, t_ifa, t_kw, t_oa, t_pz, t_af, t_al);
    chk("model 3x3 tap9 ifmd", t_ifa, 18);
    chk("model 3x3 tap9 last", int'(t_al), 1);
    tap_of(5, 5, t_ifa, t_kw, t_oa, t_pz, t_af, t_al);
    chk("model 5x5 tap6 ifmd", t_ifa, 8);
    tap_of(3, 323, t_ifa, t_kw, t_oa, t_pz, t_af, t_al);
    chk("model 3x3 final out", t_oa, 35);
`else
    tap_of(3, 0, t_ifa, t_kw, t_oa, t_pz, t_af, t_al);
    chk("model pad tap1 pad", int'(t_pz), 1);
    tap_of(3, 4, t_ifa, t_kw, t_oa, t_pz, t_af, t_al);
    chk("model pad tap5 pad", int'(t_pz), 0);
`endif

    // 3x3 plain pass
    is_5x5 = 0; start = 1; tick(); start = 0;
    watch_pass(0, 0, 0, 0, 0, 0, 0, nv, dc);
    chk("3x3 tap count", nv, N3);
    chk("3x3 done cycle", dc, N3 + 1);
    chk("3x3 tap1 ifmd", cap_ifa[1], 0);
    chk("3x3 tap1 kw", cap_kw[1], 0);
    chk("3x3 tap1 first", int'(cap_af[1]), 1);
`ifndef ZERO_PAD_EN
    chk("3x3 tap9 ifmd", cap_ifa[9], 18);
    chk("3x3 tap9 kw", cap_kw[9], 8);
    chk("3x3 tap9 last", int'(cap_al[9]), 1);
    chk("3x3 tap9 out", cap_oa[9], 0);
    chk("3x3 final ifmd", cap_ifa[324], 63);
    chk("3x3 final out", cap_oa[324], 35);
`else
    chk("pad tap1 pad", int'(cap_pz[1]), 1);
    chk("pad tap5 pad", int'(cap_pz[5]), 0);
    chk("pad tap5 ifmd", cap_ifa[5], 0);
`endif

    // 5x5 plain pass
    is_5x5 = 1; start = 1; tick(); start = 0;
    watch_pass(0, 0, 0, 0, 0, 0, 0, nv, dc);
    chk("5x5 tap count", nv, N5);
    chk("5x5 done cycle", dc, N5 + 1);
`ifndef ZERO_PAD_EN
    chk("5x5 tap6 ifmd", cap_ifa[6], 8);
    chk("5x5 final ifmd", cap_ifa[400], 63);
    chk("5x5 final kw", cap_kw[400], 24);
    chk("5x5 final out", cap_oa[400], 15);
`endif

    // 3x3 with five stall cycles where tap 10 would be issued
    is_5x5 = 0; start = 1; tick(); start = 0;
    watch_pass(10, 5, 0, 0, 0, 0, 0, nv, dc);
    chk("stall tap count", nv, N3);
    chk("stall done cycle", dc, N3 + 6);
`ifndef ZERO_PAD_EN
    chk("stall tap10 ifmd", cap_ifa[10], 1);
    chk("stall tap10 first", int'(cap_af[10]), 1);
`endif

    // start pulses while busy and in the done cycle, is_5x5 toggling
    is_5x5 = 0; start = 1; tick(); start = 0;
    watch_pass(0, 0, 40, 42, N3 + 1, 1, 0, nv, dc);
    chk("busy-start tap count", nv, N3);
    chk("busy-start done cycle", dc, N3 + 1);
    start = 1; is_5x5 = 1;
    @(negedge clk);
    chk("done-cycle start ignored busy", int'(busy), 0);
    tick(); start = 0;
    watch_pass(0, 0, 0, 0, 0, 0, 0, nv, dc);
    chk("post-done start tap count", nv, N5);
    chk("post-done start done cycle", dc, N5 + 1);

    // reset in the cycle of tap 100
    is_5x5 = 0; start = 1; tick(); start = 0;
    watch_pass(0, 0, 0, 0, 0, 0, 100, nv, dc);
    chk("pre-reset taps", nv, 100);
    @(negedge clk);
    chk("mid reset busy", int'(busy), 0);
    chk("mid reset rd_valid", int'(rd_valid), 0);
    chk("mid reset ifmd", int'(ifmd_rd_addr), 0);
    chk("mid reset kw", int'(kw_rd_addr), 0);
    chk("mid reset out", int'(out_addr), 0);
    chk("mid reset flags", int'({pad_zero, acc_first, acc_last, done}), 0);
    tick();
    start = 1; tick(); start = 0;
    watch_pass(0, 0, 0, 0, 0, 0, 0, nv, dc);
    chk("after reset tap1 ifmd", cap_ifa[1], 0);
    chk("after reset tap count", nv, N3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish by 2000000");
    $fatal(1);
  end

endmodule

// File: doc/conv_rd_addr_gen.md
# conv_rd_addr_gen

Read-side address sequencer for the 2D convolution datapath. It runs once the input-feature-map buffer (8x8, 64 words) and kernel-weight buffer (9 or 25 words) are filled. For every output pixel it walks the kernel window, issuing one ifmd/kernel read-address pair per cycle. Each pair carries accumulator framing flags for the downstream MAC stage.

## Interface
- IFMD_W, default 8: input feature map width and height; map stored row-major.
- IFMD_ADDR_W, default 6: ifmd address width; holds 0..IFMD_W*IFMD_W-1.
- KW_ADDR_W, default 5: kernel address width; holds 0..24.
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-low.
- start, in, 1: begin a convolution pass; sampled only in IDLE.
- is_5x5, in, 1: kernel size select, 1 = 5x5 and 0 = 3x3; latched on accepted start.
- stall, in, 1: freeze the sequence while high.
- busy, out, 1: high from the cycle after an accepted start through the done cycle.
- rd_valid, out, 1: the address/flag outputs hold a valid tap this cycle.
- ifmd_rd_addr, out, IFMD_ADDR_W: ifmd read address.
- kw_rd_addr, out, KW_ADDR_W: kernel read address, kr*K+kc.
- pad_zero, out, 1: tap lies outside the map, so the MAC uses 0; always 0 without ZERO_PAD_EN.
- acc_first, out, 1: first tap of the current output pixel; the MAC clears its accumulator.
- acc_last, out, 1: last tap of the current output pixel; the MAC writes its result.
- out_addr, out, IFMD_ADDR_W: output pixel index, orow*D+ocol; valid with rd_valid.
- done, out, 1: one-cycle pulse after the final tap.

## Operation
- Parameters:
  - K = 5 if the latched is_5x5 is 1, else 3. P = (K-1)/2.
  - D = IFMD_W-K+1 without padding (6 or 4); D = IFMD_W with padding.
- State machine:
  - IDLE: start=1 moves to RUN, latches is_5x5 and clears all counters.
  - RUN: each non-stalled cycle issues one tap, then advances the counters.
  - RUN → DONE after the tap where orow=ocol=D-1 and kr=kc=K-1 is issued.
  - DONE: asserts done for one cycle, then moves to IDLE.
- Counter nesting, innermost first: kc, kr, ocol, orow. Each counter wraps to 0 at its limit (K-1 or D-1) and carries into the next.
- Address arithmetic without padding:
  - r = orow+kr, c = ocol+kc.
  - ifmd_rd_addr = r*IFMD_W+c.
  - Intermediates are wide enough that no truncation occurs before the final IFMD_ADDR_W result.
- Framing flags:
  - acc_first = (kr==0 && kc==0).
  - acc_last = (kr==K-1 && kc==K-1).
- Outputs are registered. rd_valid=0 in IDLE, in DONE and during stall.
- stall=1: all counters and address outputs hold, rd_valid=0. The sequence resumes with the held tap on the first cycle with stall=0.
- start while busy: ignored. is_5x5 changes while busy: ignored.
- start arriving in the DONE cycle: ignored. A new start is accepted only in IDLE.
- rst=0 at any time, including mid-pass:
  - state returns to IDLE and all counters clear.
  - Outputs reset to busy=0, rd_valid=0, ifmd_rd_addr=0, kw_rd_addr=0, pad_zero=0, acc_first=0, acc_last=0, out_addr=0, done=0.

## Timing
- start is sampled at edge 0. The first rd_valid is at cycle 1 (one-cycle latency); busy also rises at cycle 1.
- Tap counts with no stall, no padding:
  - 3x3: 36*9 = 324 taps, valid cycles 1..324, done in cycle 325.
  - 5x5: 16*25 = 400 taps, done in cycle 401.
- Each stall cycle adds exactly one cycle to done.
- busy falls, and a new start can be accepted, in the cycle after done.
- Back-to-back passes take a minimum of N+2 cycles from start to start, where N is the tap count.

## Configuration
- Macro ZERO_PAD_EN.
- Defined: "same" convolution, D = IFMD_W.
  - r = orow+kr-P and c = ocol+kc-P, evaluated signed.
  - If r or c falls outside 0..IFMD_W-1: pad_zero=1 and ifmd_rd_addr=0.
  - Tap counts: 3x3 = 576, 5x5 = 1600.
- Undefined: "valid" convolution as in Operation; pad_zero is tied to 0.

## Test plan
- 3x3, no pad:
  - start → 324 rd_valid cycles.
  - First tap: ifmd=0, kw=0, acc_first=1.
  - Tap 9: ifmd=18, kw=8, acc_last=1, out_addr=0.
  - Final tap: ifmd=63, out_addr=35. done in cycle 325.
- 5x5, no pad:
  - 400 taps.
  - Tap 6 (kr=1, kc=0): ifmd=8.
  - Final tap: ifmd=63, kw=24, out_addr=15. done in cycle 401.
- stall held 5 cycles at tap 10:
  - rd_valid=0 and addresses frozen for those 5 cycles.
  - Tap 10 is reissued unchanged; done moves to cycle 330.
- start pulsed during busy, and is_5x5 toggled mid-pass:
  - Sequence unaffected. A start pulse in the DONE cycle is not accepted.
  - A start pulse on the cycle after done is accepted.
- rst=0 at tap 100 of a 3x3 pass:
  - All outputs at reset values next cycle.
  - A new start gives first tap ifmd=0.
- With ZERO_PAD_EN, 3x3:
  - First tap: pad_zero=1, ifmd=0.
  - Tap 5 (kr=1, kc=1): pad_zero=0, ifmd=0.
  - 576 taps; done in cycle 577.
